// File: rtl/uart_rx_checker_if.sv
// Serial input and scoring observation bus of the UART loopback checker.
// The slave modport is the checker; the master modport drives the line and watches the results.
interface uart_rx_checker_if #(
  parameter int DATA_BITS = 8,
  parameter int CNT_WIDTH = 16
);
  logic                 uart_rxd_in;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 frame_err;
  logic [CNT_WIDTH-1:0] match_count;
  logic [CNT_WIDTH-1:0] error_count;
  logic [CNT_WIDTH-1:0] ferr_count;
  logic                 pass;

  modport slave (
    input  uart_rxd_in,
    output rx_data, rx_valid, frame_err, match_count, error_count, ferr_count, pass
  );

  modport master (
    output uart_rxd_in,
    input  rx_data, rx_valid, frame_err, match_count, error_count, ferr_count, pass
  );
endinterface

// File: rtl/uart_rx_checker.sv
// UART deserializer that scores each received byte against an incrementing pattern,
// keeping saturating match/error/framing counters and a sticky-low pass flag.
module uart_rx_checker #(
  parameter int             CLKS_PER_BIT   = 868,
  parameter int             DATA_BITS      = 8,
  parameter logic [DATA_BITS-1:0] START_BYTE = '0,
  parameter int             PASS_THRESHOLD = 16,
  parameter int             CNT_WIDTH      = 16
) (
  input  logic sysclk,
  input  logic rst,
  uart_rx_checker_if.slave bus
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, RECOVER} state_t;

  state_t               state;
  logic                 s_meta, s;
  logic [CW-1:0]        clk_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] rx_data;
  logic [DATA_BITS-1:0] expected;
  logic                 rx_valid, frame_err, pass;
  logic [CNT_WIDTH-1:0] match_count, error_count, ferr_count;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    return (c == CNT_MAX) ? c : c + 1'b1;
  endfunction

  // Line idles high, so the synchronizer resets to 1 to avoid a false start bit.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      s_meta <= 1'b1;
      s      <= 1'b1;
    end else begin
      s_meta <= bus.uart_rxd_in;
      s      <= s_meta;
    end
  end

  always_ff @(posedge sysclk) begin
    if (rst) begin
      state      <= IDLE;
      clk_cnt    <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      ferr_count <= '0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          clk_cnt <= '0;
          bit_cnt <= '0;
          if (!s) state <= START;
        end
        START: begin
          if (clk_cnt == CW'(CLKS_PER_BIT/2 - 1)) begin
            clk_cnt <= '0;
            state   <= s ? IDLE : DATA;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        DATA: begin
          if (clk_cnt == CW'(CLKS_PER_BIT - 1)) begin
            clk_cnt <= '0;
            shreg   <= {s, shreg[DATA_BITS-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == BW'(DATA_BITS - 1)) state <= STOP;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        STOP: begin
          if (clk_cnt == CW'(CLKS_PER_BIT - 1)) begin
            clk_cnt <= '0;
            if (s) begin
              rx_data  <= shreg;
              rx_valid <= 1'b1;
              state    <= IDLE;
            end else begin
              frame_err  <= 1'b1;
              ferr_count <= sat_inc(ferr_count);
              state      <= RECOVER;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        RECOVER: begin
          // A held-low (break) line must not be parsed as a train of frames.
          if (s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Expected value follows the last received byte so one bad byte costs one error.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      expected    <= START_BYTE;
      match_count <= '0;
      error_count <= '0;
      pass        <= 1'b0;
    end else begin
      if (rx_valid) begin
        if (rx_data == expected) match_count <= sat_inc(match_count);
        else                     error_count <= sat_inc(error_count);
        expected <= rx_data + 1'b1;
      end
      pass <= (match_count >= CNT_WIDTH'(PASS_THRESHOLD)) &&
              (error_count == '0) && (ferr_count == '0);
    end
  end

  assign bus.rx_data     = rx_data;
  assign bus.rx_valid    = rx_valid;
  assign bus.frame_err   = frame_err;
  assign bus.match_count = match_count;
  assign bus.error_count = error_count;
  assign bus.ferr_count  = ferr_count;
  assign bus.pass        = pass;
endmodule

// File: tb/tb_uart_rx_checker.sv
// Directed bench: UART frames are driven on the line, expected bytes queued, and a
// monitor checks every rx_valid against the queue; counters are checked per scenario.
module tb_uart_rx_checker;
  localparam int CPB = 16;

  logic sysclk = 1'b0;
  logic rst    = 1'b1;
  always #5 sysclk = ~sysclk;

  uart_rx_checker_if #(.DATA_BITS(8), .CNT_WIDTH(16)) bus ();

  uart_rx_checker #(
    .CLKS_PER_BIT(CPB), .DATA_BITS(8), .START_BYTE(8'h00),
    .PASS_THRESHOLD(16), .CNT_WIDTH(16)
  ) dut (
    .sysclk(sysclk),
    .rst   (rst),
    .bus   (bus.slave)
  );

  int errors = 0;
  int checks = 0;
  int nvalid = 0;
  int nfe    = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: sample away from the active edge, pop and compare on each capture.
  always @(negedge sysclk) begin
    if (!rst && bus.rx_valid) begin
      nvalid++;
      if (exp_q.size() == 0) check("unexpected_rx_valid", {24'h0, bus.rx_data}, 32'hffff_ffff);
      else                   check("rx_data", {24'h0, bus.rx_data}, {24'h0, exp_q.pop_front()});
    end
    if (!rst && bus.frame_err) nfe++;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  task automatic bit_out(input logic v);
    bus.uart_rxd_in = v;
    idle(CPB);
  endtask

  // One frame, LSB first; a good frame is followed by a one-bit idle gap.
  task automatic send(input logic [7:0] b, input logic stop_bit, input logic push);
    if (push) exp_q.push_back(b);
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(b[i]);
    bit_out(stop_bit);
    if (stop_bit) bit_out(1'b1);
  endtask

  task automatic do_reset();
    @(negedge sysclk);
    rst = 1'b1;
    bus.uart_rxd_in = 1'b1;
    idle(3);
    rst = 1'b0;
    exp_q.delete();
    nvalid = 0;
    nfe    = 0;
    idle(2);
  endtask

  task automatic check_counts(input string tag, input int m, input int e, input int f,
                              input logic p);
    check({tag, "_match"}, {16'h0, bus.match_count}, m);
    check({tag, "_error"}, {16'h0, bus.error_count}, e);
    check({tag, "_ferr"},  {16'h0, bus.ferr_count},  f);
    check({tag, "_pass"},  {31'h0, bus.pass},        {31'h0, p});
  endtask

  initial begin
    bus.uart_rxd_in = 1'b1;
    do_reset();
    check("rst_rx_data",  {24'h0, bus.rx_data}, 0);
    check("rst_rx_valid", {31'h0, bus.rx_valid}, 0);
    check("rst_frame_err", {31'h0, bus.frame_err}, 0);
    check_counts("rst", 0, 0, 0, 1'b0);

    // Three in-order bytes: all match, below threshold.
    for (int i = 0; i < 3; i++) send(8'(i), 1'b1, 1'b1);
    idle(20);
    check("t1_nvalid", nvalid, 3);
    check_counts("t1", 3, 0, 0, 1'b0);

    // Threshold: pass must stay low at 15 matches and rise at 16.
    do_reset();
    for (int i = 0; i < 15; i++) send(8'(i), 1'b1, 1'b1);
    idle(20);
    check_counts("t2_15", 15, 0, 0, 1'b0);
    send(8'h0F, 1'b1, 1'b1);
    idle(20);
    check_counts("t2_16", 16, 0, 0, 1'b1);
    send(8'h10, 1'b1, 1'b1);
    idle(20);
    check_counts("t2_17", 17, 0, 0, 1'b1);

    // One wrong byte, resync, then enough matches to cross threshold: pass stays low.
    do_reset();
    send(8'h00, 1'b1, 1'b1);
    send(8'h01, 1'b1, 1'b1);
    send(8'h05, 1'b1, 1'b1);
    send(8'h06, 1'b1, 1'b1);
    idle(20);
    check_counts("t3", 3, 1, 0, 1'b0);
    for (int i = 7; i < 23; i++) send(8'(i), 1'b1, 1'b1);
    idle(20);
    check_counts("t3_sticky", 19, 1, 0, 1'b0);

    // Bad stop bit followed by a held-low line, then a clean frame.
    do_reset();
    send(8'h55, 1'b0, 1'b0);
    idle(40);
    check("t4_nfe", nfe, 1);
    check("t4_nvalid_bad", nvalid, 0);
    check("t4_rx_data_held", {24'h0, bus.rx_data}, 0);
    bus.uart_rxd_in = 1'b1;
    idle(CPB);
    send(8'h00, 1'b1, 1'b1);
    idle(20);
    check("t4_nvalid", nvalid, 1);
    check("t4_nfe_after", nfe, 1);
    check_counts("t4", 1, 0, 1, 1'b0);

    // Short low glitch on an idle line, then a frame to prove the FSM is idle again.
    do_reset();
    bus.uart_rxd_in = 1'b0;
    idle(5);
    bus.uart_rxd_in = 1'b1;
    idle(30);
    check("t5_nvalid", nvalid, 0);
    check("t5_nfe", nfe, 0);
    check_counts("t5", 0, 0, 0, 1'b0);
    send(8'h00, 1'b1, 1'b1);
    idle(20);
    check_counts("t5_after", 1, 0, 0, 1'b0);

    // Reset pulse during bit 4 of a frame, after a prior match.
    do_reset();
    send(8'h00, 1'b1, 1'b1);
    check_counts("t6_pre", 1, 0, 0, 1'b0);
    bit_out(1'b0);
    for (int i = 0; i < 4; i++) bit_out(1'b1 ^ i[0]);
    bus.uart_rxd_in = 1'b0;
    idle(CPB/2);
    rst = 1'b1;
    nvalid = 0;
    nfe    = 0;
    @(negedge sysclk);
    rst = 1'b0;
    bus.uart_rxd_in = 1'b1;
    idle(3 * CPB);
    check("t6_nvalid_abort", nvalid, 0);
    check("t6_nfe_abort", nfe, 0);
    check_counts("t6_rst", 0, 0, 0, 1'b0);
    send(8'h00, 1'b1, 1'b1);
    idle(20);
    check("t6_nvalid", nvalid, 1);
    check_counts("t6", 1, 0, 0, 1'b0);

    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
